scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 3: select width; output width 2**N.
REQ-002 Parameter LAST, default 2**N: number of legal codes (0..LAST-1); legal range 1 <= LAST <= 2**N.
REQ-003 Parameter DIV_W, default 4: prescaler width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  global enable; 0 freezes all state.
REQ-007 mode  in  1  0 = direct decode, 1 = auto-scan.
REQ-008 inp  in  N  code to decode in direct mode.
REQ-009 div  in  DIV_W  scan dwell length minus 1, in clk cycles.
REQ-010 out  out  2**N  registered one-hot output; all-zero when nothing is selected.
REQ-011 idx  out  N  binary index of the asserted out bit.
REQ-012 valid  out  1  high when out holds exactly one asserted bit.
REQ-013 wrap  out  1  one-cycle pulse when the scan index wraps LAST-1 -> 0.

Function
REQ-014 The FSM SHALL have states IDLE, DIRECT and SCAN; reset enters IDLE.
REQ-015 IDLE: out = 0, valid = 0; on the first edge with en=1 -> DIRECT if mode=0, else SCAN.
REQ-016 DIRECT, en=1: the block SHALL register out <= one-hot(inp), idx <= inp, valid <= 1; latency 1 clk from inp to out.
REQ-017 DIRECT, inp >= LAST: out <= 0, idx <= inp, valid <= 0 (explicit default, no held value).
REQ-018 en=0 in any state: out, idx, valid, prescaler and state SHALL hold; wrap SHALL be 0.
REQ-019 Entry to SCAN (from IDLE or DIRECT, mode=1, en=1): same edge sets idx <= 0, out <= 1 (bit 0), valid <= 1, prescaler <= 0.
REQ-020 SCAN: the prescaler increments each enabled cycle; when prescaler == div it SHALL clear and idx SHALL advance by 1 on that edge.
REQ-021 Each code SHALL therefore dwell div+1 enabled cycles; div = 0 advances every enabled cycle.
REQ-022 Advance at idx == LAST-1 SHALL set idx <= 0 and assert wrap for exactly that one cycle.
REQ-023 out SHALL always equal one-hot(idx) in SCAN; valid = 1 throughout SCAN.
REQ-024 SCAN with mode=0 and en=1 -> DIRECT on that edge: out/idx/valid from inp per REQ-016/017; prescaler cleared; wrap = 0.
REQ-025 Changing div mid-dwell SHALL take effect at the next compare; if prescaler > new div, the prescaler SHALL count up to its maximum 2**DIV_W-1 and roll over to 0 without advancing idx.
REQ-026 wrap SHALL never assert outside SCAN.
REQ-027 out SHALL never have more than one bit set in any cycle.

Reset
REQ-028 rst=1 SHALL immediately, regardless of clk: out = 0, idx = 0, valid = 0, wrap = 0, prescaler = 0, state = IDLE.
REQ-029 Reset asserted mid-scan SHALL abort the scan; after release the scan restarts from idx 0 via REQ-015/019.
REQ-030 No output SHALL change while rst=1.

Verification
REQ-031 N=3; reset, en=1, mode=0, inp=5 -> one clk later out=8'b00100000, idx=5, valid=1.
REQ-032 N=3, LAST=6; mode=0, inp=7 -> out=0, valid=0; then inp=2 -> out=8'b00000100, valid=1.
REQ-033 N=3, LAST=8; mode=1, div=2 -> idx 0,0,0,1,1,1,...; after 24 cycles idx=0 and wrap high exactly 1 cycle.
REQ-034 Mid-scan at idx=3: en=0 for 5 cycles -> idx stays 3, wrap=0; en=1 -> dwell resumes with remaining count.
REQ-035 Mid-scan at idx=4, assert rst between clk edges -> out=0 at once; release with mode=1 -> out=8'b00000001 on first enabled edge.
REQ-036 SCAN with div=0, switch mode=0 with inp=6 -> next edge out=8'b01000000, wrap=0; switch back -> idx restarts at 0.

Source files
------------

// File: rtl/scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_decoder_if : control/status bundle for scan_decoder             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface scan_decoder_if #(
  parameter int N     = 3,
  parameter int DIV_W = 4
);
  logic              en;
  logic              mode;
  logic [N-1:0]      inp;
  logic [DIV_W-1:0]  div;
  logic [2**N-1:0]   out;
  logic [N-1:0]      idx;
  logic              valid;
  logic              wrap;

  modport master (
    output en, mode, inp, div,
    input  out, idx, valid, wrap
  );

  modport slave (
    input  en, mode, inp, div,
    output out, idx, valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_decoder : registered one-hot decoder with prescaled auto-scan   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scan_decoder #(
  parameter int N     = 3,
  parameter int LAST  = 2**N,
  parameter int DIV_W = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  scan_decoder_if.slave bus
);

  localparam int              OUT_W      = 2**N;
  localparam logic [OUT_W-1:0] LEGAL_MASK = {OUT_W{1'b1}} >> (OUT_W - LAST);
  localparam logic [N-1:0]     IDX_LAST   = N'(LAST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   w_out_nxt;
  logic [N-1:0]       r_idx;
  logic [N-1:0]       w_idx_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic [DIV_W-1:0]   r_presc;
  logic [DIV_W-1:0]   w_presc_nxt;

  logic [OUT_W-1:0]   w_dec_out;
  logic               w_dec_valid;
  logic               w_presc_hit;
  logic               w_at_last;
  logic [N-1:0]       w_idx_inc;

  // Codes at or above LAST are masked off, giving an all-zero output.
  assign w_dec_out   = (OUT_W'(1) << bus.inp) & LEGAL_MASK;
  assign w_dec_valid = LEGAL_MASK[bus.inp];

  assign w_presc_hit = (r_presc == bus.div);
  assign w_at_last   = (r_idx == IDX_LAST);
  assign w_idx_inc   = w_at_last ? '0 : (r_idx + N'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_presc_nxt = r_presc;

    if (bus.en) begin
      case (r_state)
        IDLE, DIRECT: begin
          if (bus.mode) begin
            w_state_nxt = SCAN;
            w_out_nxt   = OUT_W'(1);
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_presc_nxt = '0;
          end else begin
            w_state_nxt = DIRECT;
            w_out_nxt   = w_dec_out;
            w_idx_nxt   = bus.inp;
            w_valid_nxt = w_dec_valid;
            w_presc_nxt = '0;
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            w_state_nxt = DIRECT;
            w_out_nxt   = w_dec_out;
            w_idx_nxt   = bus.inp;
            w_valid_nxt = w_dec_valid;
            w_presc_nxt = '0;
          end else if (w_presc_hit) begin
            w_presc_nxt = '0;
            w_idx_nxt   = w_idx_inc;
            w_out_nxt   = OUT_W'(1) << w_idx_inc;
            w_valid_nxt = 1'b1;
            w_wrap_nxt  = w_at_last;
          end else begin
            // A prescaler already past a shrunken div rolls over naturally.
            w_presc_nxt = r_presc + DIV_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_out_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  assign bus.out   = r_out;
  assign bus.idx   = r_idx;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// tb_scan_decoder : table vectors, directed corner sequences and random
// stimulus against a behavioural model, for two LAST settings at once.
module tb_scan_decoder;
  localparam int N      = 3;
  localparam int DIV_W  = 4;
  localparam int LAST_A = 8;
  localparam int LAST_B = 6;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic mode;
  logic [N-1:0] inp;
  logic [DIV_W-1:0] div;

  always #5 clk = ~clk;

  scan_decoder_if #(.N(N), .DIV_W(DIV_W)) bus_a ();
  scan_decoder_if #(.N(N), .DIV_W(DIV_W)) bus_b ();

  assign bus_a.en = en;   assign bus_a.mode = mode;
  assign bus_a.inp = inp; assign bus_a.div = div;
  assign bus_b.en = en;   assign bus_b.mode = mode;
  assign bus_b.inp = inp; assign bus_b.div = div;

  scan_decoder #(.N(N), .LAST(LAST_A), .DIV_W(DIV_W)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  scan_decoder #(.N(N), .LAST(LAST_B), .DIV_W(DIV_W)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 direct, 2 scan; cnt is dwell progress.
  typedef struct packed {
    int phase;
    int idx;
    int cnt;
    bit valid;
    bit wrap;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t s;
    s.phase = 0; s.idx = 0; s.cnt = 0; s.valid = 1'b0; s.wrap = 1'b0;
    return s;
  endfunction

  function automatic model_t model_next(model_t s, int last, bit e, bit m, int code, int dwell);
    if (!e) begin
      s.wrap = 1'b0;
      return s;
    end
    s.wrap = 1'b0;
    if (!m) begin
      s.phase = 1; s.idx = code; s.valid = (code < last); s.cnt = 0;
    end else if (s.phase != 2) begin
      s.phase = 2; s.idx = 0; s.valid = 1'b1; s.cnt = 0;
    end else if (s.cnt == dwell) begin
      s.cnt = 0;
      s.idx = s.idx + 1;
      if (s.idx == last) begin
        s.idx = 0;
        s.wrap = 1'b1;
      end
    end else begin
      s.cnt = (s.cnt + 1) % (1 << DIV_W);
    end
    return s;
  endfunction

  function automatic logic [7:0] exp_out(model_t s);
    return s.valid ? 8'(1 << s.idx) : 8'h00;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".a.out"},    32'(bus_a.out),   32'(exp_out(ma)));
    check({tag, ".a.idx"},    32'(bus_a.idx),   32'(ma.idx));
    check({tag, ".a.valid"},  32'(bus_a.valid), 32'(ma.valid));
    check({tag, ".a.wrap"},   32'(bus_a.wrap),  32'(ma.wrap));
    check({tag, ".b.out"},    32'(bus_b.out),   32'(exp_out(mb)));
    check({tag, ".b.idx"},    32'(bus_b.idx),   32'(mb.idx));
    check({tag, ".b.valid"},  32'(bus_b.valid), 32'(mb.valid));
    check({tag, ".b.wrap"},   32'(bus_b.wrap),  32'(mb.wrap));
    check({tag, ".a.onehot"}, 32'($countones(bus_a.out) <= 1), 32'd1);
    check({tag, ".b.onehot"}, 32'($countones(bus_b.out) <= 1), 32'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) begin
      ma = model_next(ma, LAST_A, en, mode, int'(inp), int'(div));
      mb = model_next(mb, LAST_B, en, mode, int'(inp), int'(div));
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    ma = model_reset();
    mb = model_reset();
    check({tag, ".out_now"},   32'(bus_a.out),   32'd0);
    check({tag, ".idx_now"},   32'(bus_a.idx),   32'd0);
    check({tag, ".valid_now"}, 32'(bus_a.valid), 32'd0);
    compare_all(tag);
  endtask

  typedef struct {
    logic [2:0] code;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       valid_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [2:0] saved_idx;

    vecs[0] = '{3'd5, 8'h20, 8'h20, 1'b1};
    vecs[1] = '{3'd7, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{3'd2, 8'h04, 8'h04, 1'b1};
    vecs[3] = '{3'd6, 8'h40, 8'h00, 1'b0};
    vecs[4] = '{3'd0, 8'h01, 8'h01, 1'b1};
    vecs[5] = '{3'd3, 8'h08, 8'h08, 1'b1};

    rst = 1'b0; en = 1'b0; mode = 1'b0; inp = '0; div = '0;
    ma = model_reset();
    mb = model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset.out",   32'(bus_a.out),   32'd0);
    check("reset.idx",   32'(bus_a.idx),   32'd0);
    check("reset.valid", 32'(bus_a.valid), 32'd0);
    check("reset.wrap",  32'(bus_a.wrap),  32'd0);
    step("reset_hold");
    rst = 1'b0;
    step("idle_en0");
    step("idle_en0");

    // Direct decode vectors; the first one also exercises IDLE -> DIRECT.
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inp = vecs[i].code;
      step("direct");
      check("tbl.out_a",   32'(bus_a.out),   32'(vecs[i].out_a));
      check("tbl.idx_a",   32'(bus_a.idx),   32'(vecs[i].code));
      check("tbl.valid_a", 32'(bus_a.valid), 32'd1);
      check("tbl.out_b",   32'(bus_b.out),   32'(vecs[i].out_b));
      check("tbl.valid_b", 32'(bus_b.valid), 32'(vecs[i].valid_b));
      check("tbl.idx_b",   32'(bus_b.idx),   32'(vecs[i].code));
    end

    // Auto-scan with div=2: three cycles per code, wrap after 24.
    div = 4'd2; mode = 1'b1;
    step("scan_entry");
    check("entry.out", 32'(bus_a.out), 32'h01);
    for (int k = 1; k <= 25; k++) begin
      step("scan_div2");
      check("dwell.idx",  32'(bus_a.idx),  32'((k / 3) % 8));
      check("dwell.wrap", 32'(bus_a.wrap), 32'(k == 24));
    end

    // Pause mid-dwell at idx 3.
    guard = 0;
    while (!(ma.idx == 3 && ma.cnt == 1) && guard < 60) begin
      step("seek3");
      guard++;
    end
    check("seek3.idx", 32'(bus_a.idx), 32'd3);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("pause");
      check("pause.idx",  32'(bus_a.idx),  32'd3);
      check("pause.wrap", 32'(bus_a.wrap), 32'd0);
    end
    en = 1'b1;
    step("resume");
    check("resume1.idx", 32'(bus_a.idx), 32'd3);
    step("resume");
    check("resume2.idx", 32'(bus_a.idx), 32'd4);

    // Asynchronous reset mid-scan at idx 4, then restart.
    async_reset("midreset");
    step("rst_hold");
    step("rst_hold");
    rst = 1'b0;
    step("restart");
    check("restart.out", 32'(bus_a.out), 32'h01);
    check("restart.idx", 32'(bus_a.idx), 32'd0);

    // div=0 scan, hop to direct and back.
    div = 4'd0;
    step("div0");
    check("div0.idx1", 32'(bus_a.idx), 32'd1);
    step("div0");
    check("div0.idx2", 32'(bus_a.idx), 32'd2);
    mode = 1'b0; inp = 3'd6;
    step("to_direct");
    check("todirect.out_a", 32'(bus_a.out),   32'h40);
    check("todirect.wrap",  32'(bus_a.wrap),  32'd0);
    check("todirect.out_b", 32'(bus_b.out),   32'h00);
    check("todirect.vb",    32'(bus_b.valid), 32'd0);
    mode = 1'b1;
    step("back_scan");
    check("backscan.idx", 32'(bus_a.idx), 32'd0);
    check("backscan.out", 32'(bus_a.out), 32'h01);

    // Shrinking div below the running prescaler forces a rollover.
    div = 4'd7;
    guard = 0;
    while (ma.cnt != 5 && guard < 40) begin
      step("seek_cnt5");
      guard++;
    end
    saved_idx = bus_a.idx;
    div = 4'd2;
    for (int k = 1; k <= 14; k++) begin
      step("rollover");
      if (k == 13) check("rollover.hold", 32'(bus_a.idx), 32'(saved_idx));
      if (k == 14) check("rollover.adv",  32'(bus_a.idx), 32'((saved_idx + 1) % 8));
    end

    // Randomized run against the model.
    div = 4'd1;
    for (int k = 0; k < 600; k++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) < 2) begin
        async_reset("rand_rst");
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      inp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) div = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 3));
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
